capture_ctrl: RTL and testbench

- Capture sequencer between the 8-to-32 packer and the dual-port FIFO write side, in the LVDS write clock domain.
- Decides which packed words are written to the FIFO: arm, wait for trigger match, capture a programmed number of words, stop.
- Also reports capture status (state, triggered, done, overflow, word count) for the FT601-side readout logic; that logic synchronises these flags externally.

---
 rtl/capture_ctrl.sv | 153 +++++++++++++++
 tb/tb_capture_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/capture_ctrl.sv
// capture_ctrl: capture sequencer between the word packer and the FIFO write side.
// Flow: arm, wait for a trigger match, write a programmed number of words, stop.
// Ports:
//   clk, rst_n      - capture clock, async active-low reset
//   arm, abort      - single-cycle control pulses (abort wins)
//   force_trig      - while ARMED, next valid word triggers unconditionally
//   cfg_trig_mask   - trigger compare mask (latched on arm)
//   cfg_trig_value  - trigger compare value (latched on arm)
//   cfg_post_count  - words to capture incl. trigger word, 0 = unlimited (latched on arm)
//   valid_in, data_in - packer word stream
//   fifo_full       - FIFO write-side full flag
//   wr_en_out, data_out - registered FIFO write port
//   state_out, triggered, done, overflow, words_captured - registered status
// Optional: define CAPTURE_CTRL_EDGE_TRIG_EN for an edge-sensitive trigger.
module capture_ctrl #(
    parameter int DATA_LEN = 32,
    parameter int CNT_LEN  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                arm,
    input  logic                abort,
    input  logic                force_trig,
    input  logic [DATA_LEN-1:0] cfg_trig_mask,
    input  logic [DATA_LEN-1:0] cfg_trig_value,
    input  logic [CNT_LEN-1:0]  cfg_post_count,
    input  logic                valid_in,
    input  logic [DATA_LEN-1:0] data_in,
    input  logic                fifo_full,
    output logic                wr_en_out,
    output logic [DATA_LEN-1:0] data_out,
    output logic [1:0]          state_out,
    output logic                triggered,
    output logic                done,
    output logic                overflow,
    output logic [CNT_LEN-1:0]  words_captured
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;
    state_t              state_q, state_d;
    logic [DATA_LEN-1:0] mask_q, mask_d, value_q, value_d, data_q, data_d;
    logic [CNT_LEN-1:0]  post_q, post_d, remain_q, remain_d, cnt_q, cnt_d;
    logic                wr_q, wr_d, trig_q, trig_d, ovf_q, ovf_d;
    logic                match, hit, take;
    assign match = valid_in && ((data_in & mask_q) == (value_q & mask_q));
`ifdef CAPTURE_CTRL_EDGE_TRIG_EN
    // Set only once a valid word has been seen in ARMED and failed to match,
    // so the first word after arm can never produce an edge.
    logic prev_miss_q, prev_miss_d;
    assign hit = valid_in && (force_trig || (match && prev_miss_q));
`else
    assign hit = valid_in && (force_trig || match);
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            value_q  <= '0;
            data_q   <= '0;
            post_q   <= '0;
            remain_q <= '0;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            trig_q   <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef CAPTURE_CTRL_EDGE_TRIG_EN
            prev_miss_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            value_q  <= value_d;
            data_q   <= data_d;
            post_q   <= post_d;
            remain_q <= remain_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            trig_q   <= trig_d;
            ovf_q    <= ovf_d;
`ifdef CAPTURE_CTRL_EDGE_TRIG_EN
            prev_miss_q <= prev_miss_d;
`endif
        end
    end
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        value_d  = value_q;
        data_d   = data_q;
        post_d   = post_q;
        remain_d = remain_q;
        cnt_d    = cnt_q;
        wr_d     = 1'b0;
        trig_d   = trig_q;
        ovf_d    = ovf_q;
        take     = 1'b0;
`ifdef CAPTURE_CTRL_EDGE_TRIG_EN
        prev_miss_d = prev_miss_q;
`endif
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (arm) begin
                        state_d  = ARMED;
                        mask_d   = cfg_trig_mask;
                        value_d  = cfg_trig_value;
                        post_d   = cfg_post_count;
                        remain_d = cfg_post_count;
                        cnt_d    = '0;
                        trig_d   = 1'b0;
                        ovf_d    = 1'b0;
`ifdef CAPTURE_CTRL_EDGE_TRIG_EN
                        prev_miss_d = 1'b0;
`endif
                    end
                end
                ARMED: begin
`ifdef CAPTURE_CTRL_EDGE_TRIG_EN
                    if (valid_in) prev_miss_d = !match;
`endif
                    if (hit) begin
                        state_d = CAPTURE;
                        trig_d  = 1'b1;
                        take    = 1'b1;
                    end
                end
                CAPTURE: take = valid_in;
            endcase
            // The trigger word and every later valid word go through the same write path.
            if (take) begin
                if (fifo_full) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_d   = 1'b1;
                    data_d = data_in;
                    cnt_d  = &cnt_q ? cnt_q : cnt_q + 1'b1;
                    if (post_q != '0) begin
                        remain_d = remain_q - 1'b1;
                        if (remain_q == CNT_LEN'(1)) state_d = DONE;
                    end
                end
            end
        end
    end
    assign wr_en_out      = wr_q;
    assign data_out       = data_q;
    assign state_out      = state_q;
    assign triggered      = trig_q;
    assign done           = (state_q == DONE);
    assign overflow       = ovf_q;
    assign words_captured = cnt_q;
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed self-checking bench for capture_ctrl.
module tb_capture_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, arm, abort, force_trig, valid_in, fifo_full;
    logic [31:0] cfg_trig_mask, cfg_trig_value, data_in, data_out;
    logic [15:0] cfg_post_count, words_captured;
    logic        wr_en_out, triggered, done, overflow;
    logic [1:0]  state_out;
    int          errors = 0;
    int          checks = 0;

    capture_ctrl dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .force_trig(force_trig),
        .cfg_trig_mask(cfg_trig_mask), .cfg_trig_value(cfg_trig_value),
        .cfg_post_count(cfg_post_count), .valid_in(valid_in), .data_in(data_in),
        .fifo_full(fifo_full), .wr_en_out(wr_en_out), .data_out(data_out),
        .state_out(state_out), .triggered(triggered), .done(done),
        .overflow(overflow), .words_captured(words_captured)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic f);
        valid_in  = v;
        data_in   = d;
        fifo_full = f;
        tick();
    endtask

    task automatic chk_wr(input string name, input logic w, input logic [31:0] d);
        chk({name, ".wr"}, 32'(wr_en_out), 32'(w));
        if (w) chk({name, ".data"}, data_out, d);
    endtask

    task automatic do_arm(input logic [31:0] m, input logic [31:0] v, input logic [15:0] n);
        cfg_trig_mask = m; cfg_trig_value = v; cfg_post_count = n;
        valid_in = 1'b0; arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; arm = 0; abort = 0; force_trig = 0; valid_in = 0; fifo_full = 0;
        data_in = 0; cfg_trig_mask = 0; cfg_trig_value = 0; cfg_post_count = 0;
        tick(); tick();
        chk("rst.state", 32'(state_out), 0);
        chk("rst.wr", 32'(wr_en_out), 0);
        chk("rst.data", data_out, 0);
        chk("rst.trig", 32'(triggered), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.ovf", 32'(overflow), 0);
        chk("rst.cnt", 32'(words_captured), 0);
        rst_n = 1'b1;
        tick();

        // Masked level trigger, post_count=3; cfg changed after arm must be ignored.
        do_arm(32'hFF, 32'hA5, 16'd3);
        chk("t1.armed", 32'(state_out), 1);
        cfg_trig_mask = 0; cfg_post_count = 16'd1;
        drive(1, 32'h11, 0);   chk_wr("t1.w0", 0, 0); chk("t1.st0", 32'(state_out), 1);
        drive(1, 32'h22A5, 0); chk_wr("t1.w1", 1, 32'h22A5); chk("t1.trig", 32'(triggered), 1);
        chk("t1.st1", 32'(state_out), 2);
        drive(1, 32'h33, 0);   chk_wr("t1.w2", 1, 32'h33);
        drive(1, 32'h44, 0);   chk_wr("t1.w3", 1, 32'h44);
        chk("t1.done", 32'(done), 1); chk("t1.st3", 32'(state_out), 3);
        chk("t1.cnt", 32'(words_captured), 3);
        drive(1, 32'h55, 0);   chk_wr("t1.w4", 0, 0); chk("t1.cnt2", 32'(words_captured), 3);
        drive(0, 0, 0);

        // Immediate trigger, FIFO full on second word drops it.
        do_arm(32'h0, 32'hFFFF, 16'd4);
        chk("t2.trigclr", 32'(triggered), 0);
        chk("t2.cntclr", 32'(words_captured), 0);
        drive(1, 1, 0); chk_wr("t2.w1", 1, 1);
        drive(1, 2, 1); chk_wr("t2.w2", 0, 0); chk("t2.ovf", 32'(overflow), 1);
        chk("t2.cntA", 32'(words_captured), 1);
        drive(1, 3, 0); chk_wr("t2.w3", 1, 3);
        drive(1, 4, 0); chk_wr("t2.w4", 1, 4); chk("t2.st", 32'(state_out), 2);
        drive(1, 5, 0); chk_wr("t2.w5", 1, 5); chk("t2.done", 32'(done), 1);
        drive(1, 6, 0); chk_wr("t2.w6", 0, 0);
        chk("t2.cnt", 32'(words_captured), 4); chk("t2.ovf2", 32'(overflow), 1);
        drive(0, 0, 0);

        // Unlimited capture, arm mid-capture ignored, then abort.
        do_arm(32'h0, 32'h0, 16'd0);
        chk("t3.ovfclr", 32'(overflow), 0);
        for (int i = 1; i <= 10; i++) begin
            if (i == 5) begin arm = 1'b1; cfg_post_count = 16'd2; end
            drive(1, 32'(i), 0);
            arm = 1'b0;
            chk_wr($sformatf("t3.w%0d", i), 1, 32'(i));
            chk($sformatf("t3.cnt%0d", i), 32'(words_captured), 32'(i));
        end
        chk("t3.st", 32'(state_out), 2);
        abort = 1'b1;
        drive(1, 32'hBB, 0);
        abort = 1'b0;
        chk_wr("t3.abort", 0, 0); chk("t3.idle", 32'(state_out), 0);
        chk("t3.cnt", 32'(words_captured), 10); chk("t3.trig", 32'(triggered), 1);
        drive(1, 32'hCC, 0); chk_wr("t3.after", 0, 0);
        drive(0, 0, 0);

        // arm and abort together from IDLE stays IDLE.
        abort = 1'b1;
        do_arm(32'h0, 32'h0, 16'd1);
        abort = 1'b0;
        chk("t4.idle", 32'(state_out), 0);

        // force_trig with non-matching data, post_count=1.
        do_arm(32'hFF, 32'hA5, 16'd1);
        force_trig = 1'b1;
        drive(1, 32'h0, 0); chk_wr("t5.w", 1, 0); chk("t5.done", 32'(state_out), 3);
        chk("t5.cnt", 32'(words_captured), 1);
        drive(1, 32'h0, 0); chk_wr("t5.w2", 0, 0);
        force_trig = 1'b0;
        drive(0, 0, 0);

        // Trigger mode: edge build needs a miss before a match.
        do_arm(32'hFF, 32'h01, 16'd1);
`ifdef CAPTURE_CTRL_EDGE_TRIG_EN
        drive(1, 32'h01, 0); chk_wr("t6.w1", 0, 0);
        drive(1, 32'h01, 0); chk_wr("t6.w2", 0, 0);
        drive(1, 32'h02, 0); chk_wr("t6.w3", 0, 0); chk("t6.armed", 32'(state_out), 1);
        drive(1, 32'h01, 0); chk_wr("t6.w4", 1, 32'h01);
`else
        drive(1, 32'h01, 0); chk_wr("t6.w1", 1, 32'h01);
`endif
        chk("t6.done", 32'(state_out), 3);
        drive(0, 0, 0);

        // Asynchronous reset mid-capture.
        do_arm(32'h0, 32'h0, 16'd0);
        drive(1, 32'h77, 0); chk_wr("t7.w", 1, 32'h77);
        #2 rst_n = 1'b0;
        #1;
        chk("t7.state", 32'(state_out), 0);
        chk("t7.wr", 32'(wr_en_out), 0);
        chk("t7.cnt", 32'(words_captured), 0);
        rst_n = 1'b1;
        valid_in = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
